// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS main control FSM.
// ADDI_EN adds the ADDIEX/ADDIWB states and makes opcode 001000 legal.
package mips_ctrl_pkg;

  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] J     = 6'b000010;

  localparam logic [1:0] ADD   = 2'b00;
  localparam logic [1:0] SUB   = 2'b01;
  localparam logic [1:0] FUNCT = 2'b10;

  // Encodings are fixed so the addi states leave a hole rather than renumbering.
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
`ifdef ADDI_EN
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
`endif
    JUMP    = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
  } ctrl_out_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    logic legal;
    legal = (op == LW) || (op == SW) || (op == RTYPE) || (op == BEQ) || (op == J);
`ifdef ADDI_EN
    legal = legal || (op == ADDI);
`endif
    return legal;
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Moore output decode for the main control FSM: (state, done) -> control bundle.
// ADDI_EN adds decode for the ADDIEX/ADDIWB states.
module ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_e    state,
  input  logic      done,
  output ctrl_out_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ADD;
        ctrl.ir_write  = done;
        ctrl.pc_write  = done;
      end
      DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ADD;
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ADD;
      end
      MEMRD: ctrl.i_or_d = 1'b1;
      MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      // Write strobe held through every wait cycle, not only the completing one.
      MEMWR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = FUNCT;
      end
      ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = SUB;
        ctrl.pc_src    = 2'b01;
        ctrl.branch    = 1'b1;
      end
`ifdef ADDI_EN
      ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ADD;
      end
      ADDIWB: ctrl.reg_write = 1'b1;
`endif
      JUMP: begin
        ctrl.pc_src   = 2'b10;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control FSM: state register, next-state logic, reset gating.
// ADDI_EN enables the addi path (ADDIEX -> ADDIWB); otherwise op 001000 is illegal.
module main_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       IllegalOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [1:0] ALUOp
);

  // state   | meaning
  // FETCH   | read instruction, PC += 4 when memory done
  // DECODE  | read registers, compute branch target, dispatch on Op
  // MEMADR  | compute load/store address
  // MEMRD   | memory read, waits for done
  // MEMWB   | write loaded data to rt
  // MEMWR   | memory write, waits for done
  // EXECUTE | R-type ALU operation
  // ALUWB   | write ALU result to rd
  // BRANCH  | beq compare and conditional PC update
  // ADDIEX  | addi ALU operation (ADDI_EN only)
  // ADDIWB  | write addi result to rt (ADDI_EN only)
  // JUMP    | PC <= jump target

  state_e    state_q, state_d;
  ctrl_out_t ctrl;
  logic      done;

  assign done = (MEM_WAIT != 0) ? MemReady : 1'b1;

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = done ? DECODE : FETCH;
      DECODE: begin
        if      ((Op == LW) || (Op == SW)) state_d = MEMADR;
        else if (Op == RTYPE)              state_d = EXECUTE;
        else if (Op == BEQ)                state_d = BRANCH;
`ifdef ADDI_EN
        else if (Op == ADDI)               state_d = ADDIEX;
`endif
        else if (Op == J)                  state_d = JUMP;
        else                               state_d = FETCH;
      end
      MEMADR:  state_d = (Op == LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = done ? MEMWB : MEMRD;
      MEMWB:   state_d = FETCH;
      MEMWR:   state_d = done ? FETCH : MEMWR;
      EXECUTE: state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
`ifdef ADDI_EN
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
`endif
      JUMP:    state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  ctrl_out_decode u_ctrl_out_decode (
    .state (state_q),
    .done  (done),
    .ctrl  (ctrl)
  );

  // Strobes are forced low during reset so a reset mid-access cannot commit state.
  assign PCWrite   = ctrl.pc_write  & ~Reset;
  assign IRWrite   = ctrl.ir_write  & ~Reset;
  assign MemWrite  = ctrl.mem_write & ~Reset;
  assign RegWrite  = ctrl.reg_write & ~Reset;
  assign IllegalOp = (state_q == DECODE) & ~op_is_legal(Op) & ~Reset;

  assign Branch   = ctrl.branch;
  assign IorD     = ctrl.i_or_d;
  assign RegDst   = ctrl.reg_dst;
  assign MemtoReg = ctrl.mem_to_reg;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign PCSrc    = ctrl.pc_src;
  assign ALUOp    = ctrl.alu_op;

endmodule
